// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// A transfer completes on the cycle where BusReq and BusAck are both high.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              BusReq;
  logic              BusWE;
  logic [ADDR_W-1:0] BusAddr;
  logic [3:0]        BusByteEn;
  logic [DATA_W-1:0] BusWData;
  logic              BusAck;
  logic [DATA_W-1:0] BusRData;

  modport master (
    output BusReq, BusWE, BusAddr, BusByteEn, BusWData,
    input  BusAck, BusRData
  );

  modport slave (
    input  BusReq, BusWE, BusAddr, BusByteEn, BusWData,
    output BusAck, BusRData
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store stage (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ack bus.
// Optional LSU_TIMEOUT_EN adds a watchdog that faults a REQ lasting TIMEOUT_CYCLES cycles.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Stall,
  output logic              Done,
  output logic [DATA_W-1:0] ReadData,
  output logic              Fault,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
`endif

  function automatic logic access_legal(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    if (rd && wr) begin
      ok = 1'b0;
    end else if (rd) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
    end else begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end
    // Size lives in f3[1:0] for both loads and stores.
    if (f3[1:0] == 2'b01 && off[0] != 1'b0) begin
      ok = 1'b0;
    end else if (f3[1:0] == 2'b10 && off != 2'b00) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] f3,
                                                    input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [DATA_W-1:0] rd);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    s = rd >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      store_q <= store_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, wait for ack in REQ, pulse in DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    load_d  = load_q;
    store_d = store_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d  = ALUResult;
          f3_d    = Funct3;
          load_d  = MemRead;
          store_d = MemWrite;
          wdata_d = WriteData;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
          if (!MemRead && !MemWrite) begin
            fault_d = 1'b0;
            state_d = S_DONE;
          end else if (access_legal(MemRead, MemWrite, Funct3, ALUResult[1:0])) begin
            fault_d = 1'b0;
            state_d = S_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.BusAck) begin
          if (load_q) begin
            rdata_d = load_extend(f3_q, addr_q[1:0], bus.BusRData);
          end else begin
            rdata_d = rdata_q;
          end
          state_d = S_DONE;
        end else begin
`ifdef LSU_TIMEOUT_EN
          // This cycle is the last allowed one when the count already covers the rest.
          if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs come straight from registers and are zero outside REQ.
  always_comb begin
    bus.BusReq    = 1'b0;
    bus.BusWE     = 1'b0;
    bus.BusAddr   = '0;
    bus.BusByteEn = 4'b0000;
    bus.BusWData  = '0;
    if (state_q == S_REQ) begin
      bus.BusReq    = 1'b1;
      bus.BusWE     = store_q;
      bus.BusAddr   = {addr_q[ADDR_W-1:2], 2'b00};
      bus.BusByteEn = lane_enables(f3_q, addr_q[1:0]);
      bus.BusWData  = store_lanes(f3_q, wdata_q);
    end else begin
      bus.BusReq    = 1'b0;
    end
  end

  assign Done     = (state_q == S_DONE);
  assign Fault    = (state_q == S_DONE) && fault_q;
  assign ReadData = rdata_q;
  // Dropping Stall in the DONE cycle lets the core advance exactly once.
  assign Stall    = Start && (state_q != S_DONE);

endmodule
